// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider used by EX for DIV/DIVU.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Divider sequencer states (encodings match the original defines)
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the partial
// remainder and shift in one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] dvd,
  input  logic [WIDTH-1:0] dsr,
  output logic [2*WIDTH:0] dvd_next_c
);

  logic [WIDTH:0] diff;

  assign diff = {1'b0, dvd[2*WIDTH-1:WIDTH]} - {1'b0, dsr};

  // Borrow out means the divisor did not fit: restore by simply shifting
  assign dvd_next_c = diff[WIDTH] ? (dvd << 1)
                                  : {diff[WIDTH-1:0], dvd[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned divider for DIV/DIVU; result_o carries
// {remainder, quotient} once ready_o is high.
module div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DVD_W = 2 * WIDTH + 1;

  div_state_e         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [DVD_W-1:0]   dvd, dvd_d, dvd_step;
  logic [WIDTH-1:0]   dsr, dsr_d;
  logic               q_neg, q_neg_d;
  logic               r_neg, r_neg_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d;
  logic               busy_d;

  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   quot, rem;

  // Magnitudes of the operands; the most negative value maps onto itself
  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
  assign quot = q_neg ? (~dvd[WIDTH-1:0] + WIDTH'(1)) : dvd[WIDTH-1:0];
  assign rem  = r_neg ? (~dvd[2*WIDTH:WIDTH+1] + WIDTH'(1)) : dvd[2*WIDTH:WIDTH+1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .dvd        (dvd),
    .dsr        (dsr),
    .dvd_next_c (dvd_step)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      dvd      <= dvd_d;
      dsr      <= dsr_d;
      q_neg    <= q_neg_d;
      r_neg    <= r_neg_d;
      result_o <= result_d;
      ready_o  <= ready_d;
      busy_o   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dvd_d    = dvd;
    dsr_d    = dsr;
    q_neg_d  = q_neg;
    r_neg_d  = r_neg;
    result_d = result_o;
    ready_d  = ready_o;

    unique case (state)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = '0;
            dvd_d   = {WIDTH'(0), op1_abs, 1'b0};
            dsr_d   = op2_abs;
            q_neg_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_d = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end

      // Division by zero is architecturally undefined; we return zero
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt < CNT_W'(WIDTH)) begin
          dvd_d = dvd_step;
          cnt_d = cnt + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {rem, quot};
          ready_d  = DIV_RESULT_READY;
        end
      end

      // Hold the result until EX releases start_i; flushes are not honoured here
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: state_d = DIV_FREE;
    endcase

    busy_d = (state_d == DIV_BY_ZERO) || (state_d == DIV_ON);
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the divider: stimulus queues expected results and
// per-cycle output probes, a monitor process compares them.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [63:0] res;
    string       name;
  } exp_t;

  typedef struct {
    int          at;
    logic        rdy;
    logic        bsy;
    logic [63:0] res;
    string       name;
  } probe_t;

  exp_t   sb[$];
  probe_t probes[$];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  logic   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void probe(input int at, input logic rdy, input logic bsy,
                                input logic [63:0] res, input string name);
    probe_t p;
    p.at = at; p.rdy = rdy; p.bsy = bsy; p.res = res; p.name = name;
    probes.push_back(p);
  endfunction

  function automatic void expect_result(input int at, input logic [63:0] res, input string name);
    exp_t e;
    e.at = at; e.res = res; e.name = name;
    sb.push_back(e);
  endfunction

  // Issue one operation with start held; lat is edges from the sampling edge to ready
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int lat, input string name);
    int c;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    c = cyc;
    expect_result(c + 1 + lat, exp_res, name);
    probe(c + 1, 1'b0, 1'b1, 64'd0, {name, "_busy_first"});
    if (lat > 1) probe(c + lat, 1'b0, 1'b1, 64'd0, {name, "_busy_last"});
    probe(c + 1 + lat, 1'b1, 1'b0, exp_res, {name, "_done"});
    for (int i = 0; i < lat + 5 && ready_o !== 1'b1; i++) step(1);
    start_i = 1'b0;
    step(1);
    probe(cyc, 1'b0, 1'b0, 64'd0, {name, "_release"});
    step(1);
  endtask

  // Monitor: sample mid-cycle, pop the scoreboard on each ready rising edge
  initial begin : monitor
    exp_t   e;
    probe_t p;
    logic   prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && !prev_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ready cyc=%0d result=%h", cyc, result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res || cyc != e.at) begin
            failures++;
            $display("FAIL %s result=%h cyc=%0d expected result=%h cyc=%0d",
                     e.name, result_o, cyc, e.res, e.at);
          end
        end
      end
      prev_ready = (ready_o === 1'b1);
      while (probes.size() > 0 && probes[0].at <= cyc) begin
        p = probes.pop_front();
        checks++;
        if (p.at != cyc || ready_o !== p.rdy || busy_o !== p.bsy || result_o !== p.res) begin
          failures++;
          $display("FAIL %s cyc=%0d ready=%b busy=%b result=%h expected cyc=%0d ready=%b busy=%b result=%h",
                   p.name, cyc, ready_o, busy_o, result_o, p.at, p.rdy, p.bsy, p.res);
        end
      end
      if (done) begin
        checks++;
        if (sb.size() != 0 || probes.size() != 0) begin
          failures++;
          $display("FAIL drain pending_results=%0d pending_probes=%0d expected 0 and 0",
                   sb.size(), probes.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : stimulus
    int c;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    step(2);
    probe(cyc, 1'b0, 1'b0, 64'd0, "reset_state");
    rst = 1'b1;
    step(2);

    run_op(1'b0, 32'd100,       32'd7,          {32'h0000_0002, 32'h0000_000E}, 33, "u_100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "s_m7_2");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}, 33, "u_max_1");
    run_op(1'b0, 32'd5,         32'd0,          64'd0,                          1,  "div_by_zero");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, "s_overflow");
    run_op(1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "s_7_m2");
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 33, "s_m100_m7");
    run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC}, 33, "u_big_2");
    run_op(1'b0, 32'd3,         32'd10,         {32'h0000_0003, 32'h0000_0000}, 33, "u_small");

    // Flush mid-operation: back to FREE, no result ever presented
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    c = cyc;
    step(10);
    annul_i = 1'b1;
    start_i = 1'b0;
    step(1);
    annul_i = 1'b0;
    probe(c + 11, 1'b0, 1'b0, 64'd0, "annul_free");
    probe(c + 45, 1'b0, 1'b0, 64'd0, "annul_no_ready");
    step(36);
    run_op(1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003}, 33, "u_9_3");

    // Reset mid-operation with start still held restarts a full operation
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    c = cyc;
    step(14);
    rst = 1'b0;
    step(1);
    probe(c + 15, 1'b0, 1'b0, 64'd0, "reset_mid_on");
    rst = 1'b1;
    c = cyc;
    expect_result(c + 34, {32'h0000_0002, 32'h0000_000E}, "restart_after_reset");
    probe(c + 1, 1'b0, 1'b1, 64'd0, "restart_busy");
    for (int i = 0; i < 40 && ready_o !== 1'b1; i++) step(1);
    start_i = 1'b0;
    step(1);
    probe(cyc, 1'b0, 1'b0, 64'd0, "restart_release");
    step(2);

    done = 1'b1;
    step(3);
  end

endmodule
